// File: rtl/f_fetch_unit_pkg.sv
// Shared types and constants for the F-stage fetch unit.
// Holds the fetch-state encoding, reset PC, exception vector and ExcCode values.
// No logic; imported by the fetch unit and its bench.
package f_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,   // presenting a request for pc
        ST_WAIT  = 2'd1,   // request accepted, waiting for its response
        ST_HOLD  = 2'd2,   // instruction presented to D until accepted
        ST_DRAIN = 2'd3    // waiting to swallow a response from a flushed path
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR       = 32'h0000_4180;
    localparam logic [4:0]  EXC_ADEL         = 5'd4;

endpackage

// File: rtl/f_fetch_unit_if.sv
// Instruction-memory channel: valid/ready request, valid-only response.
// master = fetch unit side, slave = instruction memory side.
// Response may only follow an accepted request, at least one cycle later.
interface f_fetch_unit_if;
    logic        im_req_valid;
    logic [31:0] im_req_addr;
    logic        im_req_ready;
    logic        im_rsp_valid;
    logic [31:0] im_rsp_data;

    modport master (
        output im_req_valid,
        output im_req_addr,
        input  im_req_ready,
        input  im_rsp_valid,
        input  im_rsp_data
    );

    modport slave (
        input  im_req_valid,
        input  im_req_addr,
        output im_req_ready,
        output im_rsp_valid,
        output im_rsp_data
    );
endinterface

// File: rtl/f_fetch_unit.sv
// F-stage fetch unit: owns the PC, fetches one instruction at a time, holds it for D.
// Latency: request issued from state; >=3 cycles per instruction (REQ, WAIT, HOLD).
// Backpressure: im_req_ready stalls REQ; stall holds the presented instruction in HOLD.
//
// Ports: clk, reset (async active-low); i_npc_in (next PC, sampled on accept);
//   i_stall, i_flush, i_flush_pc; o_F_PC/o_F_instr/o_F_valid toward D;
//   imem (f_fetch_unit_if.master) toward instruction memory.
// Optional: define F_ALIGN_CHECK_EN to add o_F_exc_adel and suppress misaligned fetches.
module f_fetch_unit
    import f_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FLUSH_PRIO = 1     // only 1 is defined: flush beats accept
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           i_npc_in,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [31:0]           i_flush_pc,
    output logic [31:0]           o_F_PC,
    output logic [31:0]           o_F_instr,
    output logic                  o_F_valid,
`ifdef F_ALIGN_CHECK_EN
    output logic                  o_F_exc_adel,
`endif
    f_fetch_unit_if.master        imem
);

    fetch_state_t r_state, w_nxt_state;
    logic [31:0]  r_pc,    w_nxt_pc;
    logic [31:0]  r_instr, w_nxt_instr;
    logic         r_valid, w_nxt_valid;
    logic         w_req_vld;
    logic         w_req_hs;
    logic         w_accept;
    logic         w_misaligned;

`ifdef F_ALIGN_CHECK_EN
    logic         r_adel, w_nxt_adel;
    assign w_misaligned = (r_pc[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // Request is a pure function of state and pc; reset gating keeps it quiet while held.
    assign w_req_vld = reset && (r_state == ST_REQ) && !w_misaligned;
    assign w_req_hs  = w_req_vld && imem.im_req_ready;
    // A same-cycle flush cancels the accept, so npc_in is never taken then.
    assign w_accept  = r_valid && !i_stall && !(i_flush && (FLUSH_PRIO != 0));

    assign imem.im_req_valid = w_req_vld;
    assign imem.im_req_addr  = r_pc;
    assign o_F_PC            = r_pc;
    assign o_F_instr         = r_instr;
    assign o_F_valid         = r_valid;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pc    = r_pc;
        w_nxt_instr = r_instr;
        w_nxt_valid = r_valid;
`ifdef F_ALIGN_CHECK_EN
        w_nxt_adel  = r_adel;
`endif
        case (r_state)
            ST_REQ: begin
                if (w_misaligned) begin
                    // Address error: present a nop instead of touching memory.
                    w_nxt_instr = 32'h0;
                    w_nxt_valid = 1'b1;
                    w_nxt_state = ST_HOLD;
`ifdef F_ALIGN_CHECK_EN
                    w_nxt_adel  = 1'b1;
`endif
                end else if (w_req_hs) begin
                    w_nxt_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.im_rsp_valid) begin
                    w_nxt_instr = imem.im_rsp_data;
                    w_nxt_valid = 1'b1;
                    w_nxt_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_accept) begin
                    w_nxt_pc    = i_npc_in;
                    w_nxt_valid = 1'b0;
                    w_nxt_state = ST_REQ;
`ifdef F_ALIGN_CHECK_EN
                    w_nxt_adel  = 1'b0;
`endif
                end
            end
            ST_DRAIN: begin
                if (imem.im_rsp_valid) w_nxt_state = ST_REQ;
            end
            default: w_nxt_state = ST_REQ;
        endcase

        // Flush overrides everything above; the only question is whether a
        // response for the abandoned path is still owed by the memory.
        if (i_flush) begin
            w_nxt_pc    = i_flush_pc;
            w_nxt_valid = 1'b0;
`ifdef F_ALIGN_CHECK_EN
            w_nxt_adel  = 1'b0;
`endif
            case (r_state)
                ST_REQ:   w_nxt_state = w_req_hs ? ST_DRAIN : ST_REQ;
                // A response landing with the flush settles the debt, even in DRAIN.
                ST_WAIT,
                ST_DRAIN: w_nxt_state = imem.im_rsp_valid ? ST_REQ : ST_DRAIN;
                default:  w_nxt_state = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_REQ;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_pc    <= w_nxt_pc;
            r_instr <= w_nxt_instr;
            r_valid <= w_nxt_valid;
        end
    end

`ifdef F_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_adel <= 1'b0;
        else        r_adel <= w_nxt_adel;
    end
    assign o_F_exc_adel = r_adel;
`endif

endmodule

// File: tb/tb_f_fetch_unit.sv
// Bench for f_fetch_unit: directed scenarios then randomized traffic.
// Reference model tracks fetch transactions (outstanding/stale/presented) at the instruction level.
// Memory model answers each accepted request after a chosen latency.
module tb_f_fetch_unit;
    import f_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] npc_in = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic [31:0] f_pc, f_instr;
    logic        f_valid;
`ifdef F_ALIGN_CHECK_EN
    logic        f_exc_adel;
`endif

    f_fetch_unit_if imem ();

    f_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .i_npc_in   (npc_in),
        .i_stall    (stall),
        .i_flush    (flush),
        .i_flush_pc (flush_pc),
        .o_F_PC     (f_pc),
        .o_F_instr  (f_instr),
        .o_F_valid  (f_valid),
`ifdef F_ALIGN_CHECK_EN
        .o_F_exc_adel (f_exc_adel),
`endif
        .imem       (imem)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc    = RESET_PC_DEFAULT;  // architectural PC the unit should hold
    logic        m_pres  = 1'b0;   // an instruction is being offered to D
    logic [31:0] m_instr = '0;
    logic        m_adel  = 1'b0;
    logic        m_out   = 1'b0;   // memory owes a response
    logic        m_stale = 1'b0;   // that response belongs to a flushed path
    int          m_cnt   = 0;
    logic [31:0] m_addr  = '0;
    int          lat     = 1;
    logic        ovr_vld = 1'b0;
    logic [31:0] ovr_dat = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic model_req();
`ifdef F_ALIGN_CHECK_EN
        return !m_out && !m_pres && (m_pc[1:0] == 2'b00);
`else
        return !m_out && !m_pres;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Rsp while the unit is requesting or presenting is illegal traffic from the memory side.
    always @(posedge clk)
        if (reset && imem.im_rsp_valid)
            assert (!imem.im_req_valid && !f_valid)
                else $error("protocol: response while not waiting");

    // One clock: check visible outputs, drive inputs, advance the model to the next edge.
    task automatic tick(input logic st, input logic fl, input logic [31:0] fpc,
                        input logic [31:0] npc, input logic rdy);
        logic        exp_req, hs, rsp, was_pres, idle;
        logic [31:0] dat, old_pc;
        @(negedge clk);
        exp_req = model_req();
        check_eq("req_valid", 32'(imem.im_req_valid), 32'(exp_req));
        if (exp_req) check_eq("req_addr", imem.im_req_addr, m_pc);
        check_eq("f_valid", 32'(f_valid), 32'(m_pres));
        check_eq("f_pc", f_pc, m_pc);
        if (m_pres) check_eq("f_instr", f_instr, m_instr);
`ifdef F_ALIGN_CHECK_EN
        check_eq("f_exc_adel", 32'(f_exc_adel), 32'(m_adel));
`endif
        rsp = m_out && (m_cnt == 0);
        dat = ovr_vld ? ovr_dat : mem_word(m_addr);
        if (rsp) ovr_vld = 1'b0;
        stall = st; flush = fl; flush_pc = fpc; npc_in = npc;
        imem.im_req_ready = rdy;
        imem.im_rsp_valid = rsp;
        imem.im_rsp_data  = rsp ? dat : 32'hx;

        hs = exp_req && rdy;
        was_pres = m_pres;
        idle = !m_out && !m_pres;
        old_pc = m_pc;
        if (fl) begin
            m_pc = fpc; m_pres = 1'b0; m_adel = 1'b0;
            if (rsp) begin m_out = 1'b0; m_stale = 1'b0; end
            else if (hs || m_out) m_stale = 1'b1;
        end else begin
            if (rsp) begin
                m_out = 1'b0;
                if (!m_stale) begin m_pres = 1'b1; m_instr = dat; end
                m_stale = 1'b0;
            end
            if (was_pres && !st) begin m_pres = 1'b0; m_pc = npc; m_adel = 1'b0; end
`ifdef F_ALIGN_CHECK_EN
            if (idle && old_pc[1:0] != 2'b00) begin
                m_pres = 1'b1; m_instr = 32'h0; m_adel = 1'b1;
            end
`endif
        end
        if (rsp) m_out = 1'b0;
        if (hs) begin
            m_out = 1'b1; m_addr = old_pc; m_cnt = lat - 1;
        end else if (m_out) begin
            m_cnt--;
        end
    endtask

    // Run plain fetch cycles until an instruction is offered, then sample it after the edge.
    task automatic to_hold();
        int n = 0;
        while (!m_pres && n < 50) begin
            tick(1'b0, 1'b0, 32'h0, $urandom, 1'b1);
            n++;
        end
        @(posedge clk); #1;
        check_eq("hold_reached", 32'(f_valid), 32'd1);
    endtask

    task automatic expect_hold(input string tag, input logic [31:0] pc);
        check_eq({tag, "_pc"}, f_pc, pc);
        check_eq({tag, "_instr"}, f_instr, mem_word(pc));
    endtask

    initial begin
        imem.im_req_ready = 1'b0;
        imem.im_rsp_valid = 1'b0;
        imem.im_rsp_data  = '0;

        // Reset held low: nothing requested, nothing presented.
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_req_valid", 32'(imem.im_req_valid), 32'd0);
            check_eq("rst_f_valid", 32'(f_valid), 32'd0);
            check_eq("rst_f_instr", f_instr, 32'h0);
            check_eq("rst_pc", f_pc, RESET_PC_DEFAULT);
        end
        reset = 1'b1;

        // Sequential fetch with a stall window and a branch.
        lat = 1;
        to_hold(); expect_hold("seq0", 32'h3000);
        tick(1'b0, 1'b0, 32'h0, 32'h3004, 1'b1);
        to_hold(); expect_hold("seq1", 32'h3004);
        repeat (4) tick(1'b1, 1'b0, 32'h0, $urandom, 1'b1);
        check_eq("stall_pc", f_pc, 32'h3004);
        tick(1'b0, 1'b0, 32'h0, 32'h3008, 1'b1);
        to_hold(); expect_hold("seq2", 32'h3008);
        tick(1'b0, 1'b0, 32'h0, 32'h3040, 1'b1);
        to_hold(); expect_hold("branch", 32'h3040);
        tick(1'b0, 1'b0, 32'h0, 32'h300C, 1'b1);

        // Flush one cycle after the handshake; the late response must be dropped.
        lat = 3; ovr_vld = 1'b1; ovr_dat = 32'hDEAD_BEEF;
        tick(1'b0, 1'b0, 32'h0, $urandom, 1'b1);
        lat = 1;
        tick(1'b0, 1'b1, EXC_VECTOR, $urandom, 1'b1);
        to_hold(); expect_hold("drain", EXC_VECTOR);

        // Flush in HOLD with stall low: accept cancelled, npc_in ignored.
        tick(1'b0, 1'b1, EXC_VECTOR, 32'h0000_5000, 1'b1);
        @(posedge clk); #1;
        check_eq("flush_hold_valid", 32'(f_valid), 32'd0);
        check_eq("flush_hold_addr", imem.im_req_addr, EXC_VECTOR);

        // Flush coinciding with the response in WAIT.
        tick(1'b0, 1'b0, 32'h0, $urandom, 1'b1);
        tick(1'b0, 1'b1, EXC_VECTOR, $urandom, 1'b1);
        to_hold(); expect_hold("flush_rsp", EXC_VECTOR);

`ifdef F_ALIGN_CHECK_EN
        tick(1'b0, 1'b0, 32'h0, 32'h3002, 1'b1);
        @(posedge clk); #1;
        check_eq("adel_no_req", 32'(imem.im_req_valid), 32'd0);
        to_hold();
        check_eq("adel_pc", f_pc, 32'h3002);
        check_eq("adel_instr", f_instr, 32'h0);
        check_eq("adel_flag", 32'(f_exc_adel), 32'd1);
        tick(1'b1, 1'b1, EXC_VECTOR, $urandom, 1'b1);
        @(posedge clk); #1;
        check_eq("adel_clear", 32'(f_exc_adel), 32'd0);
`endif

        // Randomized traffic: ready, latency, stall, flush and redirects all vary.
        for (int i = 0; i < 3000; i++) begin
            logic        st, fl, rdy;
            logic [31:0] fpc, npc;
            st  = ($urandom_range(0, 9) < 3);
            fl  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            fpc = $urandom & 32'hFFFF_FFFC;
            npc = ($urandom_range(0, 9) < 7) ? m_pc + 32'd4 : ($urandom & 32'hFFFF_FFFC);
            lat = $urandom_range(1, 4);
            tick(st, fl, fpc, npc, rdy);
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
